// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: opcode set and tag/register sentinels shared by dispatcher, RS, LSB and RoB.
package reorder_buffer_pkg;
  localparam int EX_RoB_WIDTH = 9;
  localparam int EX_REG_WIDTH = 6;
  localparam logic [EX_RoB_WIDTH-1:0] NON_DEP = 9'b1_0000_0000;
  localparam logic [EX_REG_WIDTH-1:0] NON_REG = 6'b10_0000;
  typedef enum logic [6:0] {
    lui, auipc, jal, jalr,
    beq, bne, blt, bge, bltu, bgeu,
    lb, lh, lw, lbu, lhu,
    sb, sh, sw,
    addi, slti, sltiu, xori, ori, andi, slli, srli, srai,
    add, sub, sll, slt, sltu, xorr, srl, sra, orr, andd
  } opcode_e;
  function automatic logic is_branch(input logic [6:0] op);
    return op >= beq && op <= bgeu;
  endfunction
  function automatic logic is_store(input logic [6:0] op);
    return op inside {sb, sh, sw};
  endfunction
  function automatic logic is_jump(input logic [6:0] op);
    return op == jal || op == jalr;
  endfunction
endpackage

// File: rtl/rob_branch_judge.sv
// rob_branch_judge: resolves branch direction, mispredict and redirect target of the head entry.
module rob_branch_judge
  import reorder_buffer_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [31:0] pc,
  input  logic        predict,
  input  logic [31:0] value,
  output logic        taken,
  output logic        mispredict,
  output logic [31:0] redirect_pc
);
  // A branch result is its correct next pc, so a fall-through target means not taken.
  assign taken = value != pc + 32'd4;
  assign mispredict = is_branch(opcode) ? taken != predict : opcode == jalr;
  assign redirect_pc = value;
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order RoB; allocates, answers operand queries, captures CDB results,
// commits one entry per cycle and flushes with a redirect on mispredict or jalr.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int RoB_WIDTH = 8
) (
  input  logic                    Sys_clk,
  input  logic                    Sys_rst_n,
  input  logic                    Sys_rdy,
  input  logic                    DPRoB_en,
  input  logic [31:0]             DPRoB_pc,
  input  logic                    DPRoB_predict_result,
  input  logic [6:0]              DPRoB_opcode,
  input  logic [EX_REG_WIDTH-1:0] DPRoB_rd,
  input  logic [EX_RoB_WIDTH-1:0] DPRoB_Qj,
  input  logic [EX_RoB_WIDTH-1:0] DPRoB_Qk,
  output logic                    RoBDP_full,
  output logic [RoB_WIDTH-1:0]    RoBDP_RoB_index,
  output logic                    RoBDP_pre_judge,
  output logic                    RoBDP_Qj_ready,
  output logic                    RoBDP_Qk_ready,
  output logic [31:0]             RoBDP_Vj,
  output logic [31:0]             RoBDP_Vk,
  input  logic                    CDBDP_RS_en,
  input  logic [RoB_WIDTH-1:0]    CDBDP_RS_RoB_index,
  input  logic [31:0]             CDBDP_RS_value,
  input  logic                    CDBDP_LSB_en,
  input  logic [RoB_WIDTH-1:0]    CDBDP_LSB_RoB_index,
  input  logic [31:0]             CDBDP_LSB_value,
  output logic                    RoBRF_en,
  output logic [EX_REG_WIDTH-1:0] RoBRF_rd,
  output logic [RoB_WIDTH-1:0]    RoBRF_RoB_index,
  output logic [31:0]             RoBRF_value,
  output logic                    RoBLSB_store_en,
  output logic [RoB_WIDTH-1:0]    RoBLSB_RoB_index,
  output logic                    RoBPR_en,
  output logic [31:0]             RoBPR_pc,
  output logic                    RoBPR_taken,
  output logic [31:0]             RoBIF_jump_pc
);
  localparam int RoB_SIZE = 1 << RoB_WIDTH;
  localparam int CW = RoB_WIDTH + 1;

  logic [RoB_WIDTH-1:0]    head, tail;
  logic [CW-1:0]           count;
  logic [RoB_SIZE-1:0]     busy, ready;
  logic [31:0]             pc_mem     [RoB_SIZE];
  logic [6:0]              opcode_mem [RoB_SIZE];
  logic [EX_REG_WIDTH-1:0] rd_mem     [RoB_SIZE];
  logic                    predict_mem[RoB_SIZE];
  logic [31:0]             value_mem  [RoB_SIZE];

  logic [RoB_WIDTH-1:0] qj_idx, qk_idx;
  logic [6:0]           head_op;
  logic [31:0]          head_pc, head_value, redirect_pc;
  logic                 live, alloc, commit, flush, taken, mispredict;

  assign qj_idx = DPRoB_Qj[RoB_WIDTH-1:0];
  assign qk_idx = DPRoB_Qk[RoB_WIDTH-1:0];
  assign RoBDP_Qj_ready = DPRoB_Qj != NON_DEP && busy[qj_idx] && ready[qj_idx];
  assign RoBDP_Qk_ready = DPRoB_Qk != NON_DEP && busy[qk_idx] && ready[qk_idx];
  assign RoBDP_Vj = value_mem[qj_idx];
  assign RoBDP_Vk = value_mem[qk_idx];
  assign RoBDP_full = count == CW'(RoB_SIZE);
  assign RoBDP_RoB_index = tail;

  // The flush cycle (pre_judge low) freezes allocation, capture and commit.
  assign live = Sys_rdy && RoBDP_pre_judge;
  assign alloc = live && DPRoB_en && !RoBDP_full;
  assign commit = live && count != '0 && ready[head];
  assign flush = commit && mispredict;
  assign head_op = opcode_mem[head];
  assign head_pc = pc_mem[head];
  assign head_value = value_mem[head];

  rob_branch_judge judge (
    .opcode(head_op),
    .pc(head_pc),
    .predict(predict_mem[head]),
    .value(head_value),
    .taken(taken),
    .mispredict(mispredict),
    .redirect_pc(redirect_pc)
  );

  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      busy <= '0;
      ready <= '0;
      RoBDP_pre_judge <= 1'b1;
      RoBIF_jump_pc <= '0;
      RoBRF_en <= 1'b0;
      RoBRF_rd <= '0;
      RoBRF_RoB_index <= '0;
      RoBRF_value <= '0;
      RoBLSB_store_en <= 1'b0;
      RoBLSB_RoB_index <= '0;
      RoBPR_en <= 1'b0;
      RoBPR_pc <= '0;
      RoBPR_taken <= 1'b0;
    end else begin
      RoBRF_en <= commit && rd_mem[head] != NON_REG;
      RoBLSB_store_en <= commit && is_store(head_op);
      RoBPR_en <= commit && is_branch(head_op);
      if (commit) begin
        RoBRF_rd <= rd_mem[head];
        RoBRF_RoB_index <= head;
        RoBRF_value <= is_jump(head_op) ? head_pc + 32'd4 : head_value;
        RoBLSB_RoB_index <= head;
        RoBPR_pc <= head_pc;
        RoBPR_taken <= taken;
      end
      if (Sys_rdy) RoBDP_pre_judge <= !flush;
      if (flush) begin
        RoBIF_jump_pc <= redirect_pc;
        head <= '0;
        tail <= '0;
        count <= '0;
        busy <= '0;
      end else if (live) begin
        if (alloc) begin
          busy[tail] <= 1'b1;
          ready[tail] <= 1'b0;
          pc_mem[tail] <= DPRoB_pc;
          opcode_mem[tail] <= DPRoB_opcode;
          rd_mem[tail] <= DPRoB_rd;
          predict_mem[tail] <= DPRoB_predict_result;
          tail <= tail + 1'b1;
        end
        if (CDBDP_RS_en && busy[CDBDP_RS_RoB_index]) begin
          ready[CDBDP_RS_RoB_index] <= 1'b1;
          value_mem[CDBDP_RS_RoB_index] <= CDBDP_RS_value;
        end
        if (CDBDP_LSB_en && busy[CDBDP_LSB_RoB_index]) begin
          ready[CDBDP_LSB_RoB_index] <= 1'b1;
          value_mem[CDBDP_LSB_RoB_index] <= CDBDP_LSB_value;
        end
        if (commit) begin
          busy[head] <= 1'b0;
          head <= head + 1'b1;
        end
        count <= count + CW'(alloc) - CW'(commit);
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus random traffic, checked every cycle against a queue model.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic        Sys_clk = 0, Sys_rst_n = 0, Sys_rdy = 1;
  logic        DPRoB_en = 0, DPRoB_predict_result = 0;
  logic [31:0] DPRoB_pc = 0;
  logic [6:0]  DPRoB_opcode = 0;
  logic [5:0]  DPRoB_rd = 0;
  logic [8:0]  DPRoB_Qj = 0, DPRoB_Qk = 0;
  logic        RoBDP_full, RoBDP_pre_judge, RoBDP_Qj_ready, RoBDP_Qk_ready;
  logic [1:0]  RoBDP_RoB_index;
  logic [31:0] RoBDP_Vj, RoBDP_Vk;
  logic        CDBDP_RS_en = 0, CDBDP_LSB_en = 0;
  logic [1:0]  CDBDP_RS_RoB_index = 0, CDBDP_LSB_RoB_index = 0;
  logic [31:0] CDBDP_RS_value = 0, CDBDP_LSB_value = 0;
  logic        RoBRF_en, RoBLSB_store_en, RoBPR_en, RoBPR_taken;
  logic [5:0]  RoBRF_rd;
  logic [1:0]  RoBRF_RoB_index, RoBLSB_RoB_index;
  logic [31:0] RoBRF_value, RoBPR_pc, RoBIF_jump_pc;

  reorder_buffer #(.RoB_WIDTH(2)) dut (
    .Sys_clk(Sys_clk), .Sys_rst_n(Sys_rst_n), .Sys_rdy(Sys_rdy),
    .DPRoB_en(DPRoB_en), .DPRoB_pc(DPRoB_pc), .DPRoB_predict_result(DPRoB_predict_result),
    .DPRoB_opcode(DPRoB_opcode), .DPRoB_rd(DPRoB_rd), .DPRoB_Qj(DPRoB_Qj), .DPRoB_Qk(DPRoB_Qk),
    .RoBDP_full(RoBDP_full), .RoBDP_RoB_index(RoBDP_RoB_index), .RoBDP_pre_judge(RoBDP_pre_judge),
    .RoBDP_Qj_ready(RoBDP_Qj_ready), .RoBDP_Qk_ready(RoBDP_Qk_ready),
    .RoBDP_Vj(RoBDP_Vj), .RoBDP_Vk(RoBDP_Vk),
    .CDBDP_RS_en(CDBDP_RS_en), .CDBDP_RS_RoB_index(CDBDP_RS_RoB_index), .CDBDP_RS_value(CDBDP_RS_value),
    .CDBDP_LSB_en(CDBDP_LSB_en), .CDBDP_LSB_RoB_index(CDBDP_LSB_RoB_index), .CDBDP_LSB_value(CDBDP_LSB_value),
    .RoBRF_en(RoBRF_en), .RoBRF_rd(RoBRF_rd), .RoBRF_RoB_index(RoBRF_RoB_index), .RoBRF_value(RoBRF_value),
    .RoBLSB_store_en(RoBLSB_store_en), .RoBLSB_RoB_index(RoBLSB_RoB_index),
    .RoBPR_en(RoBPR_en), .RoBPR_pc(RoBPR_pc), .RoBPR_taken(RoBPR_taken),
    .RoBIF_jump_pc(RoBIF_jump_pc)
  );

  always #5 Sys_clk = ~Sys_clk;

  int checks = 0, failures = 0;
  bit checking = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] pc;
    logic [6:0]  op;
    logic [5:0]  rd;
    logic        pred;
    logic        rdy;
    logic [31:0] val;
  } ent_t;

  ent_t        q[$];
  logic [1:0]  m_tail = 0;
  logic        m_pre = 1;
  logic [31:0] m_jump = 0;
  logic        e_rf = 0, e_st = 0, e_pr = 0, e_tk = 0;
  logic [5:0]  e_rd = 0;
  logic [1:0]  e_rf_idx = 0, e_st_idx = 0;
  logic [31:0] e_rf_val = 0, e_pr_pc = 0;

  // In-order queue of live instructions; the head retires once its result has arrived.
  always @(posedge Sys_clk) begin
    bit was_full, do_commit, redirect, tk;
    ent_t h;
    if (!Sys_rst_n) begin
      q.delete();
      m_tail = 0;
      m_pre = 1;
      m_jump = 0;
      e_rf = 0; e_st = 0; e_pr = 0;
    end else begin
      e_rf = 0; e_st = 0; e_pr = 0;
      if (!m_pre) m_pre = 1;
      else begin
        was_full = q.size() == 4;
        do_commit = q.size() > 0 && q[0].rdy;
        redirect = 0;
        if (do_commit) h = q[0];
        foreach (q[i]) begin
          if (CDBDP_RS_en && q[i].idx == CDBDP_RS_RoB_index) begin q[i].rdy = 1; q[i].val = CDBDP_RS_value; end
          if (CDBDP_LSB_en && q[i].idx == CDBDP_LSB_RoB_index) begin q[i].rdy = 1; q[i].val = CDBDP_LSB_value; end
        end
        if (do_commit) begin
          void'(q.pop_front());
          tk = h.val != h.pc + 32'd4;
          e_rf = h.rd != NON_REG;
          e_rd = h.rd;
          e_rf_idx = h.idx;
          e_rf_val = (h.op == jal || h.op == jalr) ? h.pc + 32'd4 : h.val;
          e_st = h.op inside {sb, sh, sw};
          e_st_idx = h.idx;
          e_pr = h.op inside {beq, bne, blt, bge, bltu, bgeu};
          e_pr_pc = h.pc;
          e_tk = tk;
          redirect = (e_pr && tk != h.pred) || h.op == jalr;
        end
        if (redirect) begin
          q.delete();
          m_tail = 0;
          m_pre = 0;
          m_jump = h.val;
        end else if (DPRoB_en && !was_full) begin
          q.push_back('{m_tail, DPRoB_pc, DPRoB_opcode, DPRoB_rd, DPRoB_predict_result, 1'b0, 32'h0});
          m_tail = m_tail + 2'd1;
        end
      end
    end
  end

  function automatic void model_query(input logic [8:0] tag, output logic rdy, output logic [31:0] val);
    rdy = 0;
    val = 0;
    if (tag != NON_DEP)
      foreach (q[i])
        if (q[i].idx == tag[1:0]) begin rdy = q[i].rdy; val = q[i].val; end
  endfunction

  always @(negedge Sys_clk) begin
    logic qr;
    logic [31:0] qv;
    if (checking) begin
      chk("full", RoBDP_full, q.size() == 4);
      chk("rob_index", RoBDP_RoB_index, m_tail);
      chk("pre_judge", RoBDP_pre_judge, m_pre);
      chk("jump_pc", RoBIF_jump_pc, m_jump);
      chk("rf_en", RoBRF_en, e_rf);
      chk("store_en", RoBLSB_store_en, e_st);
      chk("pr_en", RoBPR_en, e_pr);
      if (e_rf) begin
        chk("rf_rd", RoBRF_rd, e_rd);
        chk("rf_index", RoBRF_RoB_index, e_rf_idx);
        chk("rf_value", RoBRF_value, e_rf_val);
      end
      if (e_st) chk("store_index", RoBLSB_RoB_index, e_st_idx);
      if (e_pr) begin
        chk("pr_pc", RoBPR_pc, e_pr_pc);
        chk("pr_taken", RoBPR_taken, e_tk);
      end
      model_query(DPRoB_Qj, qr, qv);
      chk("qj_ready", RoBDP_Qj_ready, qr);
      if (qr) chk("vj", RoBDP_Vj, qv);
      model_query(DPRoB_Qk, qr, qv);
      chk("qk_ready", RoBDP_Qk_ready, qr);
      if (qr) chk("vk", RoBDP_Vk, qv);
    end
  end

  task automatic cyc();
    @(posedge Sys_clk);
    #2;
  endtask

  task automatic idle();
    DPRoB_en = 0;
    CDBDP_RS_en = 0;
    CDBDP_LSB_en = 0;
  endtask

  task automatic do_reset();
    idle();
    Sys_rst_n = 0;
    cyc();
    Sys_rst_n = 1;
  endtask

  task automatic alloc(input logic [6:0] op, input logic [31:0] pc, input logic [5:0] rd, input logic pred);
    DPRoB_en = 1;
    DPRoB_opcode = op;
    DPRoB_pc = pc;
    DPRoB_rd = rd;
    DPRoB_predict_result = pred;
    cyc();
    DPRoB_en = 0;
  endtask

  task automatic rs(input logic [1:0] idx, input logic [31:0] val);
    CDBDP_RS_en = 1; CDBDP_RS_RoB_index = idx; CDBDP_RS_value = val;
    cyc();
    CDBDP_RS_en = 0;
  endtask

  task automatic lsb(input logic [1:0] idx, input logic [31:0] val);
    CDBDP_LSB_en = 1; CDBDP_LSB_RoB_index = idx; CDBDP_LSB_value = val;
    cyc();
    CDBDP_LSB_en = 0;
  endtask

  task automatic rand_inputs();
    logic [6:0] ops [9];
    int k, tries;
    ops = '{addi, lw, sw, beq, bne, bltu, jal, jalr, lui};
    DPRoB_en = $urandom_range(0, 3) != 0;
    DPRoB_opcode = ops[$urandom_range(0, 8)];
    DPRoB_pc = $urandom & 32'hFFFF_FFFC;
    DPRoB_predict_result = 1'($urandom_range(0, 1));
    DPRoB_rd = (is_store(DPRoB_opcode) || is_branch(DPRoB_opcode) || $urandom_range(0, 7) == 0)
               ? NON_REG : 6'($urandom_range(0, 31));
    DPRoB_Qj = $urandom_range(0, 7) == 0 ? NON_DEP : 9'($urandom_range(0, 3));
    DPRoB_Qk = $urandom_range(0, 7) == 0 ? NON_DEP : 9'($urandom_range(0, 3));
    CDBDP_RS_en = 0;
    CDBDP_LSB_en = 0;
    if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
      k = $urandom_range(0, q.size() - 1);
      if (!q[k].rdy) begin
        CDBDP_RS_en = 1;
        CDBDP_RS_RoB_index = q[k].idx;
        CDBDP_RS_value = is_branch(q[k].op)
          ? ($urandom_range(0, 1) ? q[k].pc + 32'd4 : q[k].pc + 32'(4 * $urandom_range(2, 64)))
          : $urandom;
      end
    end
    if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
      for (tries = 0; tries < 4; tries++) begin
        k = $urandom_range(0, q.size() - 1);
        if (!q[k].rdy && !(CDBDP_RS_en && CDBDP_RS_RoB_index == q[k].idx)) begin
          CDBDP_LSB_en = 1;
          CDBDP_LSB_RoB_index = q[k].idx;
          CDBDP_LSB_value = $urandom;
          break;
        end
      end
    end
  endtask

  initial begin
    idle();
    Sys_rst_n = 0;
    cyc();
    cyc();
    checking = 1;
    Sys_rst_n = 1;
    DPRoB_Qj = 9'd0;
    #1;
    chk("reset_full", RoBDP_full, 0);
    chk("reset_index", RoBDP_RoB_index, 0);
    chk("reset_pre_judge", RoBDP_pre_judge, 1);
    chk("reset_rf_en", RoBRF_en, 0);
    chk("reset_jump_pc", RoBIF_jump_pc, 0);
    chk("reset_qj_ready", RoBDP_Qj_ready, 0);

    for (int i = 0; i < 4; i++) alloc(addi, 32'h10 + 32'(4 * i), 6'd5, 0);
    chk("fill_full", RoBDP_full, 1);
    chk("fill_index", RoBDP_RoB_index, 0);
    rs(2'd0, 32'h2A);
    DPRoB_Qj = 9'd0;
    #1;
    chk("fwd_qj_ready", RoBDP_Qj_ready, 1);
    chk("fwd_vj", RoBDP_Vj, 32'h2A);
    chk("fwd_still_full", RoBDP_full, 1);
    cyc();
    chk("commit_rf_en", RoBRF_en, 1);
    chk("commit_rf_rd", RoBRF_rd, 5);
    chk("commit_rf_value", RoBRF_value, 32'h2A);
    chk("commit_full_drop", RoBDP_full, 0);

    do_reset();
    alloc(beq, 32'h100, NON_REG, 1);
    alloc(addi, 32'h104, 6'd3, 0);
    chk("pre_flush_index", RoBDP_RoB_index, 2);
    rs(2'd0, 32'h104);
    DPRoB_en = 1;
    DPRoB_opcode = addi;
    cyc();
    DPRoB_en = 0;
    chk("flush_pre_judge", RoBDP_pre_judge, 0);
    chk("flush_jump_pc", RoBIF_jump_pc, 32'h104);
    chk("flush_pr_en", RoBPR_en, 1);
    chk("flush_pr_taken", RoBPR_taken, 0);
    chk("flush_index", RoBDP_RoB_index, 0);
    cyc();
    chk("after_flush_pre_judge", RoBDP_pre_judge, 1);
    chk("after_flush_empty_index", RoBDP_RoB_index, 0);

    alloc(jal, 32'h200, 6'd1, 0);
    rs(2'd0, 32'h777);
    cyc();
    chk("jal_rf_en", RoBRF_en, 1);
    chk("jal_rf_value", RoBRF_value, 32'h204);
    cyc();
    chk("jal_no_flush", RoBDP_pre_judge, 1);

    do_reset();
    alloc(sw, 32'h300, NON_REG, 0);
    alloc(lw, 32'h304, 6'd7, 0);
    lsb(2'd1, 32'h55);
    cyc();
    chk("order_no_store", RoBLSB_store_en, 0);
    chk("order_no_rf", RoBRF_en, 0);
    lsb(2'd0, 32'h0);
    chk("order_still_no_store", RoBLSB_store_en, 0);
    cyc();
    chk("order_store_en", RoBLSB_store_en, 1);
    chk("order_store_idx", RoBLSB_RoB_index, 0);
    chk("order_rf_not_yet", RoBRF_en, 0);
    cyc();
    chk("order_lw_rf_en", RoBRF_en, 1);
    chk("order_lw_value", RoBRF_value, 32'h55);
    chk("order_store_done", RoBLSB_store_en, 0);

    alloc(addi, 32'h308, 6'd2, 0);
    alloc(addi, 32'h30C, 6'd3, 0);
    CDBDP_RS_en = 1; CDBDP_RS_RoB_index = 2'd2; CDBDP_RS_value = 32'h11;
    CDBDP_LSB_en = 1; CDBDP_LSB_RoB_index = 2'd3; CDBDP_LSB_value = 32'h22;
    cyc();
    idle();
    DPRoB_Qj = 9'd2;
    DPRoB_Qk = 9'd3;
    #1;
    chk("dual_qj_ready", RoBDP_Qj_ready, 1);
    chk("dual_qk_ready", RoBDP_Qk_ready, 1);
    chk("dual_vj", RoBDP_Vj, 32'h11);
    chk("dual_vk", RoBDP_Vk, 32'h22);

    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      cyc();
    end

    rand_inputs();
    Sys_rst_n = 0;
    cyc();
    Sys_rst_n = 1;
    idle();
    DPRoB_Qj = 9'd0;
    #1;
    chk("midrst_full", RoBDP_full, 0);
    chk("midrst_index", RoBDP_RoB_index, 0);
    chk("midrst_pre_judge", RoBDP_pre_judge, 1);
    chk("midrst_rf_en", RoBRF_en, 0);
    chk("midrst_rf_value", RoBRF_value, 0);
    chk("midrst_store_en", RoBLSB_store_en, 0);
    chk("midrst_pr_en", RoBPR_en, 0);
    chk("midrst_jump_pc", RoBIF_jump_pc, 0);
    chk("midrst_qj_ready", RoBDP_Qj_ready, 0);
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
